// File: rtl/phy_rst_pkg.sv
// phy_rst_pkg: channel states, 50 MHz default timings and counter sizing for phy_reset_seq
package phy_rst_pkg;
  typedef enum logic [1:0] {ST_ASSERT, ST_POST, ST_READY} state_t;
  localparam int unsigned DEF_RST_ASSERT_CYC = 1048576;
  localparam int unsigned DEF_POST_RST_CYC   = 250000;
  localparam int unsigned DEF_STAGGER_CYC    = 50000;
  localparam int unsigned DEF_DEBOUNCE_CYC   = 500000;
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: 2-flop synchroniser plus debounce counter; press pulses on the edge the level falls
module pb_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 8,
  parameter int unsigned W            = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_n,
  output logic press,
  output logic level
);
  logic s1, s2;
  logic [W-1:0] cnt;
  logic done;
  assign done  = cnt == W'(DEBOUNCE_CYC - 1);
  assign press = level & ~s2 & done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      s1 <= pb_n;
      s2 <= s1;
      if (s2 != level) begin
        if (done) begin
          level <= s2;
          cnt   <= '0;
        end else cnt <= cnt + W'(1);
      end else cnt <= '0;
    end
endmodule

// File: rtl/phy_reset_seq.sv
// phy_reset_seq: staggered power-on / on-demand reset sequencer for NUM_PHY Ethernet PHYs
module phy_reset_seq import phy_rst_pkg::*; #(
  parameter int unsigned NUM_PHY        = 2,
  parameter int unsigned RST_ASSERT_CYC = DEF_RST_ASSERT_CYC,
  parameter int unsigned POST_RST_CYC   = DEF_POST_RST_CYC,
  parameter int unsigned STAGGER_CYC    = DEF_STAGGER_CYC,
  parameter int unsigned DEBOUNCE_CYC   = DEF_DEBOUNCE_CYC,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               clk_50_max10,
  input  logic               fpga_resetn,
  input  logic               pb_resetn,
  input  logic [NUM_PHY-1:0] rst_req,
  output logic [NUM_PHY-1:0] phy_resetn,
  output logic [NUM_PHY-1:0] phy_ready,
  output logic               all_ready,
  output logic               busy,
  output logic [CNT_W-1:0]   reset_cnt
);
  localparam int unsigned CW = cnt_width(RST_ASSERT_CYC + (NUM_PHY - 1) * STAGGER_CYC,
                                         POST_RST_CYC, DEBOUNCE_CYC);
  if (NUM_PHY < 1 || NUM_PHY > 8 || RST_ASSERT_CYC == 0 || POST_RST_CYC == 0 ||
      STAGGER_CYC == 0 || DEBOUNCE_CYC == 0 || CNT_W == 0) begin : g_bad_cfg
    $error("phy_reset_seq: illegal parameter set");
  end
  logic press, level, group;
  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .W(CW)) u_debounce (
    .clk   (clk_50_max10),
    .rst_n (fpga_resetn),
    .pb_n  (pb_resetn),
    .press (press),
    .level (level)
  );
  // holding the load while the button stays down makes release timing start at button release
  assign group = press | ~level;
  for (genvar i = 0; i < NUM_PHY; i++) begin : g_ch
    localparam logic [CW-1:0] LOAD = CW'(RST_ASSERT_CYC + i * STAGGER_CYC);
    state_t st;
    logic [CW-1:0] cnt;
    logic rn, rdy;
    always_ff @(posedge clk_50_max10 or negedge fpga_resetn)
      if (!fpga_resetn) begin
        st  <= ST_ASSERT;
        cnt <= LOAD;
        rn  <= 1'b0;
        rdy <= 1'b0;
      end else if (group || rst_req[i]) begin
        st  <= ST_ASSERT;
        cnt <= group ? LOAD : CW'(RST_ASSERT_CYC);
        rn  <= 1'b0;
        rdy <= 1'b0;
      end else if (st == ST_ASSERT) begin
        if (cnt == CW'(1)) begin
          st  <= ST_POST;
          cnt <= CW'(POST_RST_CYC);
          rn  <= 1'b1;
        end else cnt <= cnt - CW'(1);
      end else if (st == ST_POST) begin
        if (cnt == CW'(1)) begin
          st  <= ST_READY;
          rdy <= 1'b1;
        end else cnt <= cnt - CW'(1);
      end
    assign phy_resetn[i] = rn;
    assign phy_ready[i]  = rdy;
  end
  always_ff @(posedge clk_50_max10 or negedge fpga_resetn)
    if (!fpga_resetn) begin
      all_ready <= 1'b0;
      busy      <= 1'b1;
      reset_cnt <= '0;
    end else begin
      all_ready <= &phy_ready;
      busy      <= ~&phy_ready;
      reset_cnt <= (press || |rst_req) && reset_cnt != '1 ? reset_cnt + CNT_W'(1) : reset_cnt;
    end
endmodule

// File: tb/tb_phy_reset_seq.sv
// tb_phy_reset_seq: directed table plus hand sequences for phy_reset_seq with short timings
module tb_phy_reset_seq;
  logic       clk, rstn, pb;
  logic [1:0] req, rn, rdy;
  logic       ar, bz;
  logic [7:0] cnt;
  int checks = 0, errors = 0;

  typedef struct {
    int         e;
    logic [1:0] req;
    logic [1:0] rn;
    logic [1:0] rdy;
    logic       ar;
    logic       bz;
    logic [7:0] cnt;
  } vec_t;
  vec_t tbl[17];

  phy_reset_seq #(
    .NUM_PHY(2), .RST_ASSERT_CYC(20), .POST_RST_CYC(10), .STAGGER_CYC(5),
    .DEBOUNCE_CYC(8), .CNT_W(8)
  ) dut (
    .clk_50_max10 (clk),
    .fpga_resetn  (rstn),
    .pb_resetn    (pb),
    .rst_req      (req),
    .phy_resetn   (rn),
    .phy_ready    (rdy),
    .all_ready    (ar),
    .busy         (bz),
    .reset_cnt    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_table(input int lo, input int hi);
    int cur = 0;
    for (int i = lo; i <= hi; i++) begin
      adv(tbl[i].e - cur);
      cur = tbl[i].e;
      chk($sformatf("phy_resetn@%0d", cur), 32'(rn),  32'(tbl[i].rn));
      chk($sformatf("phy_ready@%0d", cur),  32'(rdy), 32'(tbl[i].rdy));
      chk($sformatf("all_ready@%0d", cur),  32'(ar),  32'(tbl[i].ar));
      chk($sformatf("busy@%0d", cur),       32'(bz),  32'(tbl[i].bz));
      chk($sformatf("reset_cnt@%0d", cur),  32'(cnt), 32'(tbl[i].cnt));
      req = tbl[i].req;
    end
  endtask

  initial begin
    tbl[0]  = '{19,  2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 8'd0};
    tbl[1]  = '{20,  2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 8'd0};
    tbl[2]  = '{24,  2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 8'd0};
    tbl[3]  = '{25,  2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 8'd0};
    tbl[4]  = '{29,  2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 8'd0};
    tbl[5]  = '{30,  2'b00, 2'b11, 2'b01, 1'b0, 1'b1, 8'd0};
    tbl[6]  = '{34,  2'b00, 2'b11, 2'b01, 1'b0, 1'b1, 8'd0};
    tbl[7]  = '{35,  2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 8'd0};
    tbl[8]  = '{36,  2'b00, 2'b11, 2'b11, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{99,  2'b10, 2'b11, 2'b11, 1'b1, 1'b0, 8'd0};
    tbl[10] = '{100, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0, 8'd1};
    tbl[11] = '{101, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 8'd1};
    tbl[12] = '{119, 2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 8'd1};
    tbl[13] = '{120, 2'b00, 2'b11, 2'b01, 1'b0, 1'b1, 8'd1};
    tbl[14] = '{129, 2'b00, 2'b11, 2'b01, 1'b0, 1'b1, 8'd1};
    tbl[15] = '{130, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 8'd1};
    tbl[16] = '{131, 2'b00, 2'b11, 2'b11, 1'b1, 1'b0, 8'd1};

    rstn = 1'b0; pb = 1'b1; req = 2'b00;
    adv(3);
    chk("rst phy_resetn", 32'(rn), 32'h0);
    chk("rst phy_ready", 32'(rdy), 32'h0);
    chk("rst all_ready", 32'(ar), 32'h0);
    chk("rst busy", 32'(bz), 32'h1);
    chk("rst reset_cnt", 32'(cnt), 32'h0);
    rstn = 1'b1;
    run_table(0, 16);

    // short glitch on the button is filtered
    pb = 1'b0; adv(5); pb = 1'b1; adv(20);
    chk("glitch phy_resetn", 32'(rn), 32'h3);
    chk("glitch reset_cnt", 32'(cnt), 32'd1);

    // long press: low 10 edges after press, released with stagger 10 edges after button release
    pb = 1'b0; adv(9);
    chk("press+9 phy_resetn", 32'(rn), 32'h3);
    adv(1);
    chk("press+10 phy_resetn", 32'(rn), 32'h0);
    chk("press+10 phy_ready", 32'(rdy), 32'h0);
    chk("press reset_cnt", 32'(cnt), 32'd2);
    adv(90);
    chk("held phy_resetn", 32'(rn), 32'h0);
    pb = 1'b1; adv(29);
    chk("rel+29 phy_resetn", 32'(rn), 32'h0);
    adv(1);
    chk("rel+30 phy_resetn", 32'(rn), 32'h1);
    adv(4);
    chk("rel+34 phy_resetn", 32'(rn), 32'h1);
    adv(1);
    chk("rel+35 phy_resetn", 32'(rn), 32'h3);
    adv(10);
    chk("rel+45 phy_ready", 32'(rdy), 32'h3);
    chk("rel+45 reset_cnt", 32'(cnt), 32'd2);
    adv(1);
    chk("rel+46 all_ready", 32'(ar), 32'h1);

    // retriggered request on channel 0
    req = 2'b01; adv(1); req = 2'b00;
    chk("req0 phy_resetn", 32'(rn), 32'h2);
    chk("req0 phy_ready", 32'(rdy), 32'h2);
    adv(9); req = 2'b01; adv(1); req = 2'b00;
    chk("retrig phy_resetn", 32'(rn), 32'h2);
    adv(19);
    chk("retrig+29 phy_resetn", 32'(rn), 32'h2);
    adv(1);
    chk("retrig+30 phy_resetn", 32'(rn), 32'h3);
    chk("retrig reset_cnt", 32'(cnt), 32'd4);
    adv(10);
    chk("retrig phy_ready", 32'(rdy), 32'h3);

    // asynchronous reset while channel 0 settles
    req = 2'b01; adv(1); req = 2'b00; adv(24);
    chk("post phy_resetn", 32'(rn), 32'h3);
    chk("post phy_ready", 32'(rdy), 32'h2);
    #2 rstn = 1'b0;
    #1;
    chk("async phy_resetn", 32'(rn), 32'h0);
    chk("async phy_ready", 32'(rdy), 32'h0);
    chk("async all_ready", 32'(ar), 32'h0);
    chk("async busy", 32'(bz), 32'h1);
    chk("async reset_cnt", 32'(cnt), 32'h0);
    #1 rstn = 1'b1;
    run_table(0, 8);

    // press and request together: staggered group timing, one count
    pb = 1'b0; adv(9); req = 2'b11; adv(1); req = 2'b00; pb = 1'b1;
    chk("both phy_resetn", 32'(rn), 32'h0);
    chk("both reset_cnt", 32'(cnt), 32'd1);
    adv(29);
    chk("both+39 phy_resetn", 32'(rn), 32'h0);
    adv(1);
    chk("both+40 phy_resetn", 32'(rn), 32'h1);
    adv(4);
    chk("both+44 phy_resetn", 32'(rn), 32'h1);
    adv(1);
    chk("both+45 phy_resetn", 32'(rn), 32'h3);
    adv(5);
    chk("both+50 phy_ready", 32'(rdy), 32'h1);
    adv(5);
    chk("both+55 phy_ready", 32'(rdy), 32'h3);

    // saturation of the event counter
    req = 2'b11; adv(253);
    chk("sat-1 reset_cnt", 32'(cnt), 32'd254);
    chk("held req phy_resetn", 32'(rn), 32'h0);
    adv(1);
    chk("sat reset_cnt", 32'(cnt), 32'd255);
    adv(46); req = 2'b00;
    chk("sat hold reset_cnt", 32'(cnt), 32'd255);
    adv(19);
    chk("sat+19 phy_resetn", 32'(rn), 32'h0);
    adv(1);
    chk("sat+20 phy_resetn", 32'(rn), 32'h3);
    adv(11);
    chk("sat all_ready", 32'(ar), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phy_reset_seq.md
Name: phy_reset_seq

Overview:
Parametrised power-on and on-demand reset sequencer for NUM_PHY Ethernet PHYs. It generalises the single fixed power-on delay counter to the following:
- Per-channel configurable assert and settle times.
- Staggered release across channels.
- Per-channel software reset requests.
- A debounced push-button reset that resets all channels.
- Per-channel and global ready status.

It sits at the top level between the board reset/button inputs and the PHY reset pins, and its ready flags gate MAC/system reset release.

Parameters:
NUM_PHY, 2, number of PHY channels (legal range 1..8)
RST_ASSERT_CYC, 1048576, minimum cycles phy_resetn is held low (≥10 ms at 50 MHz)
POST_RST_CYC, 250000, settle cycles after release before phy_ready asserts
STAGGER_CYC, 50000, extra assert cycles per channel index on group resets
DEBOUNCE_CYC, 500000, cycles the synchronised button must be stable before the debounced level changes
CNT_W, 8, width of the saturating reset-event counter

Ports:
clk_50_max10  in   1        system clock, 50 MHz
fpga_resetn   in   1        asynchronous active-low reset
pb_resetn     in   1        asynchronous push-button input, active low (pressed = 0)
rst_req       in   NUM_PHY  per-channel software reset request, level sampled each cycle
phy_resetn    out  NUM_PHY  active-low PHY reset pins, registered
phy_ready     out  NUM_PHY  channel out of reset and settled, registered
all_ready     out  1        AND of all phy_ready, registered
busy          out  1        any channel not in READY, registered
reset_cnt     out  CNT_W    saturating count of reset events since fpga_resetn

Behaviour:
- One clock (clk_50_max10); reset fpga_resetn is asynchronous, active-low.
- While fpga_resetn = 0: phy_resetn = 0, phy_ready = 0, all_ready = 0, busy = 1, reset_cnt = 0.
  - Every channel is in ST_ASSERT with counter = RST_ASSERT_CYC + i*STAGGER_CYC.
  - Synchroniser flops and the debounced level are 1; the debounce counter is 0.
- Per-channel FSM (three states):
  - ST_ASSERT: phy_resetn[i] = 0; counter decrements each cycle; at counter = 1, go to ST_POST and load POST_RST_CYC.
  - ST_POST: phy_resetn[i] = 1, phy_ready[i] = 0; at counter = 1, go to ST_READY.
  - ST_READY: phy_resetn[i] = 1, phy_ready[i] = 1; the channel stays here until a reset event.
- Timing, counting the first rising edge with fpga_resetn high as edge 1:
  - phy_resetn[i] rises after edge A_i = RST_ASSERT_CYC + i*STAGGER_CYC.
  - phy_ready[i] rises after edge A_i + POST_RST_CYC.
  - all_ready and busy update one edge after the last phy_ready change.
- rst_req[i] = 1 sampled at edge N, in any state:
  - Channel i goes to ST_ASSERT with counter = RST_ASSERT_CYC (no stagger).
  - phy_resetn[i] and phy_ready[i] are 0 after edge N.
  - A request while already in ST_ASSERT reloads the counter (retrigger).
  - A request held high keeps the channel in ST_ASSERT.
  - Other channels are unaffected.
- Button path:
  - pb_resetn passes through a 2-flop synchroniser.
  - The debounced level toggles only after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles; any return to the current level clears the debounce counter.
  - A 1→0 transition of the debounced level is a group reset: all channels go to ST_ASSERT with staggered loads.
  - While the debounced level is 0, all counters reload every cycle, so release timing starts when the debounced level returns to 1.
- Simultaneous group reset and rst_req in the same cycle: the group reset wins (staggered load for every channel).
- reset_cnt:
  - Increments by 1 per debounced press.
  - Increments by 1 per cycle in which any rst_req bit is high and no press occurs.
  - Saturates at 2^CNT_W-1; no wrap.
- Counter width is $clog2(RST_ASSERT_CYC + (NUM_PHY-1)*STAGGER_CYC + 1), also covering POST_RST_CYC and DEBOUNCE_CYC; counters never underflow.
- Elaboration error if NUM_PHY is outside 1..8 or any *_CYC is 0.

Decomposition:
- Package phy_rst_pkg holds:
  - the state typedef enum {ST_ASSERT, ST_POST, ST_READY};
  - default cycle constants for 50 MHz;
  - the counter-width function.
- Sub-module pb_debounce holds the 2-flop synchroniser, debounce counter and debounced level, and outputs a one-cycle press pulse plus the held level.
- The channel FSMs are generated inline in phy_reset_seq.

Test Plan (NUM_PHY=2, RST_ASSERT_CYC=20, POST_RST_CYC=10, STAGGER_CYC=5, DEBOUNCE_CYC=8):
1. Release fpga_resetn -> phy_resetn[0] rises after edge 20 and [1] after edge 25; phy_ready[0] after edge 30 and [1] after edge 35; all_ready = 1 and busy = 0 after edge 36.
2. rst_req[1] pulse at edge 100 -> phy_resetn[1], phy_ready[1] and all_ready are 0 after edge 100/101; phy_resetn[1] rises after edge 120 and phy_ready[1] after edge 130; channel 0 stays ready; reset_cnt = 1.
3. pb_resetn low for 5 cycles -> no change. pb_resetn low for 100 cycles -> both phy_resetn go low 10 cycles after the press (2 sync + 8 debounce) and stay low while held. Release -> phy_resetn[0] rises 10 + 20 cycles after release and [1] 5 cycles later.
4. rst_req[0] pulses at edges N and N+10 -> phy_resetn[0] rises after edge N+30 (retriggered).
5. fpga_resetn pulled low while channel 0 is in ST_POST -> all outputs return to reset values asynchronously; reset_cnt = 0. On release, the scenario 1 timing repeats.
6. 300 rst_req pulses -> reset_cnt saturates at 255. Press and rst_req in the same cycle -> staggered group timing and a single reset_cnt increment.
